// File: rtl/display7seg_bank_if.sv
// Input/output bundle of the 7-segment display bank: digit codes and control in,
// segment drives and blink phase out.
interface display7seg_bank_if #(
    parameter int unsigned N_DIGITS = 6
);
    logic                      load;
    logic [5*N_DIGITS-1:0]     codes;
    logic [N_DIGITS-1:0]       blink_en;
    logic                      zero_blank;
    logic                      mode;
    logic [7*N_DIGITS-1:0]     displays;
    logic                      phase;

    modport master (
        output load, codes, blink_en, zero_blank, mode,
        input  displays, phase
    );

    modport slave (
        input  load, codes, blink_en, zero_blank, mode,
        output displays, phase
    );
endinterface

// File: rtl/display7seg_bank.sv
// Registered bank of N 7-segment decoders with load-strobed digit registers,
// per-digit blinking, leading-zero blanking and a chase animation mode.
module display7seg_bank #(
    parameter int unsigned N_DIGITS  = 6,
    parameter int unsigned BLINK_DIV = 25_000_000
) (
    input logic               clock,
    input logic               reset,
    display7seg_bank_if.slave bus
);
    localparam int unsigned     CntW   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(BLINK_DIV - 1);

    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  phase_q, phase_d;
    logic [2:0]            step_q, step_d;
    logic [4:0]            code_q [N_DIGITS];
    logic [4:0]            code_d [N_DIGITS];
    logic [N_DIGITS-1:0]   blink_q, blink_d;
    logic                  zb_q, zb_d;
    logic                  mode_q, mode_d;
    logic [7*N_DIGITS-1:0] disp_q, disp_d;

    logic                  wrap;
    logic                  all_zero;
    logic [N_DIGITS-1:0]   lz_blank;
    logic [6:0]            seg;

    function automatic logic [6:0] seg_decode(input logic [4:0] code);
        case (code)
            5'h00:   return 7'b1000000;
            5'h01:   return 7'b1111001;
            5'h02:   return 7'b0100100;
            5'h03:   return 7'b0110000;
            5'h04:   return 7'b0011001;
            5'h05:   return 7'b0010010;
            5'h06:   return 7'b0000010;
            5'h07:   return 7'b1111000;
            5'h08:   return 7'b0000000;
            5'h09:   return 7'b0010000;
            5'h0A:   return 7'b0001000;
            5'h0B:   return 7'b0000011;
            5'h0C:   return 7'b1000110;
            5'h0D:   return 7'b0100001;
            5'h0E:   return 7'b0000110;
            5'h0F:   return 7'b0001110;
            5'h10:   return 7'b1111110;
            5'h11:   return 7'b1111101;
            5'h12:   return 7'b1111011;
            5'h13:   return 7'b1110111;
            5'h14:   return 7'b1101111;
            5'h15:   return 7'b1011111;
            default: return 7'b1111111;
        endcase
    endfunction

    always_comb begin
        wrap    = (cnt_q == CntMax);
        cnt_d   = wrap ? '0 : cnt_q + 1'b1;
        phase_d = phase_q ^ wrap;
        step_d  = step_q;
        if (wrap) begin
            step_d = (step_q == 3'd5) ? 3'd0 : step_q + 3'd1;
        end

        code_d  = code_q;
        blink_d = blink_q;
        zb_d    = zb_q;
        mode_d  = mode_q;
        if (bus.load) begin
            for (int i = 0; i < int'(N_DIGITS); i++) begin
                code_d[i] = bus.codes[5*i +: 5];
            end
            blink_d = bus.blink_en;
            zb_d    = bus.zero_blank;
            mode_d  = bus.mode;
        end
    end

    // Digit i is a leading zero when it and every digit above it hold code 0.
    always_comb begin
        lz_blank = '0;
        all_zero = 1'b1;
        for (int i = int'(N_DIGITS) - 1; i >= 1; i--) begin
            all_zero    = all_zero & (code_q[i] == 5'd0);
            lz_blank[i] = all_zero;
        end
    end

    always_comb begin
        disp_d = '1;
        seg    = '1;
        for (int i = 0; i < int'(N_DIGITS); i++) begin
            if (mode_q) begin
                seg = seg_decode({2'b10, step_q});
            end else if ((zb_q && lz_blank[i]) || (blink_q[i] && phase_q)) begin
                seg = 7'b1111111;
            end else begin
                seg = seg_decode(code_q[i]);
            end
            disp_d[7*i +: 7] = seg;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
            step_q  <= 3'd0;
            blink_q <= '0;
            zb_q    <= 1'b0;
            mode_q  <= 1'b0;
            disp_q  <= '1;
            for (int i = 0; i < int'(N_DIGITS); i++) begin
                code_q[i] <= 5'h1F;
            end
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            step_q  <= step_d;
            blink_q <= blink_d;
            zb_q    <= zb_d;
            mode_q  <= mode_d;
            disp_q  <= disp_d;
            for (int i = 0; i < int'(N_DIGITS); i++) begin
                code_q[i] <= code_d[i];
            end
        end
    end

    assign bus.displays = disp_q;
    assign bus.phase    = phase_q;
endmodule

// File: tb/tb_display7seg_bank.sv
// Scoreboard bench for display7seg_bank: a digit-level reference model predicts each
// edge's displays/phase into a queue; a monitor compares after every rising edge.
module tb_display7seg_bank;
    localparam int unsigned N  = 6;
    localparam int unsigned BD = 4;

    typedef struct packed {
        logic [7*N-1:0] disp;
        logic           phase;
    } exp_t;

    logic clock = 1'b0;
    logic reset;

    display7seg_bank_if #(.N_DIGITS(N)) bus ();

    display7seg_bank #(.N_DIGITS(N), .BLINK_DIV(BD)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    logic [6:0] seg_tab [32];
    exp_t       sb_q [$];
    int         n_checks = 0;
    int         n_fail   = 0;

    // Reference state, kept as plain integers/arrays
    int         m_cnt, m_step;
    bit         m_phase, m_zb, m_mode;
    bit [N-1:0] m_blink;
    int         m_code [N];

    function automatic logic [7*N-1:0] model_display();
        logic [7*N-1:0] d;
        int hi;
        bit blank;
        d  = '1;
        hi = -1;
        for (int i = 0; i < int'(N); i++) if (m_code[i] != 0) hi = i;
        for (int i = 0; i < int'(N); i++) begin
            if (m_mode) begin
                d[7*i +: 7] = seg_tab[16 + m_step];
            end else begin
                blank = (m_zb && i > 0 && i > hi) || (m_blink[i] && m_phase);
                d[7*i +: 7] = blank ? 7'b1111111 : seg_tab[m_code[i]];
            end
        end
        return d;
    endfunction

    // Predict the outcome of the coming rising edge from the current inputs.
    function automatic void model_edge();
        exp_t e;
        if (reset) begin
            e.disp  = '1;
            m_cnt   = 0;
            m_phase = 1'b0;
            m_step  = 0;
            m_zb    = 1'b0;
            m_mode  = 1'b0;
            m_blink = '0;
            for (int i = 0; i < int'(N); i++) m_code[i] = 31;
        end else begin
            e.disp = model_display();
            if (m_cnt == int'(BD) - 1) begin
                m_cnt   = 0;
                m_phase = ~m_phase;
                m_step  = (m_step + 1) % 6;
            end else begin
                m_cnt = m_cnt + 1;
            end
            if (bus.load) begin
                for (int i = 0; i < int'(N); i++) m_code[i] = int'(bus.codes[5*i +: 5]);
                m_blink = bus.blink_en;
                m_zb    = bus.zero_blank;
                m_mode  = bus.mode;
            end
        end
        e.phase = m_phase;
        sb_q.push_back(e);
    endfunction

    task automatic step_cycle();
        model_edge();
        @(negedge clock);
    endtask

    task automatic apply(input bit r, input bit ld, input logic [5*N-1:0] c,
                         input logic [N-1:0] b, input bit z, input bit m, input int idle);
        reset          = r;
        bus.load       = ld;
        bus.codes      = c;
        bus.blink_en   = b;
        bus.zero_blank = z;
        bus.mode       = m;
        step_cycle();
        reset    = 1'b0;
        bus.load = 1'b0;
        for (int k = 0; k < idle; k++) step_cycle();
    endtask

    function automatic logic [5*N-1:0] pack6(input int c5, c4, c3, c2, c1, c0);
        logic [4:0] v [6];
        v[0] = 5'(c0); v[1] = 5'(c1); v[2] = 5'(c2);
        v[3] = 5'(c3); v[4] = 5'(c4); v[5] = 5'(c5);
        return {v[5], v[4], v[3], v[2], v[1], v[0]};
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_checks++;
                if (bus.displays !== e.disp) begin
                    n_fail++;
                    $display("FAIL displays at %0t: got %b expected %b", $time, bus.displays,
                             e.disp);
                end
                n_checks++;
                if (bus.phase !== e.phase) begin
                    n_fail++;
                    $display("FAIL phase at %0t: got %b expected %b", $time, bus.phase, e.phase);
                end
            end
        end
    end

    initial begin : stimulus
        logic [5*N-1:0] c;
        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110,
                    7'b1111110, 7'b1111101, 7'b1111011, 7'b1110111,
                    7'b1101111, 7'b1011111, 7'b1111111, 7'b1111111,
                    7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111,
                    7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111};
        m_cnt = 0; m_step = 0; m_phase = 0; m_zb = 0; m_mode = 0; m_blink = '0;
        for (int i = 0; i < int'(N); i++) m_code[i] = 31;

        apply(1, 0, '0, '0, 0, 0, 2);
        apply(1, 0, '0, '0, 0, 0, 12);
        apply(0, 1, pack6(21, 20, 15, 10, 9, 0), '0, 0, 0, 6);
        apply(0, 1, pack6(0, 0, 0, 3, 0, 0), '0, 1, 0, 4);
        apply(0, 1, pack6(0, 0, 0, 0, 0, 0), '0, 1, 0, 4);
        c = pack6(8, 8, 8, 8, 8, 8);
        apply(0, 1, c, 6'b000100, 0, 0, 14);
        apply(0, 1, c, 6'b000100, 0, 1, 30);
        apply(0, 1, c, 6'b000100, 0, 0, 8);
        apply(0, 1, c, '0, 0, 1, 13);
        apply(1, 0, '0, '0, 0, 0, 9);
        // load held high across several edges with changing content
        apply(0, 1, pack6(1, 2, 3, 4, 5, 6), '0, 0, 0, 0);
        apply(0, 1, pack6(0, 0, 7, 0, 0, 1), 6'b100001, 1, 0, 0);
        apply(0, 1, pack6(0, 0, 0, 12, 13, 14), 6'b000010, 1, 0, 10);

        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < int'(N); i++)
                c[5*i +: 5] = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            reset          = ($urandom_range(0, 99) == 0);
            bus.load       = ($urandom_range(0, 3) == 0);
            bus.codes      = c;
            bus.blink_en   = N'($urandom);
            bus.zero_blank = 1'($urandom);
            bus.mode       = ($urandom_range(0, 4) == 0);
            step_cycle();
        end
        reset    = 1'b0;
        bus.load = 1'b0;
        @(posedge clock);
        #4;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
